// File: rtl/dma_block_avail_emulator_pkg.sv
// Shared types and helpers for the DMA block-availability emulator.
// Block sizes arrive in bytes; thresholds are tracked in dwords.
package caliptra_top_tb_pkg;

    typedef enum logic [2:0] {
        DMA_AV_IDLE   = 3'd0,
        DMA_AV_LOAD   = 3'd1,
        DMA_AV_BYPASS = 3'd2,
        DMA_AV_FILL   = 3'd3,
        DMA_AV_AVAIL  = 3'd4,
        DMA_AV_DONE   = 3'd5
    } dma_avail_state_e;

    function automatic logic [31:0] ceil_div4(
        input logic [31:0] nbytes
    );
        return (nbytes + 32'd3) >> 2;
    endfunction

endpackage

// File: rtl/dma_block_avail_emulator_if.sv
// FIFO beat bundle seen by the block-availability emulator.
// master drives the beats, slave observes them.
interface dma_block_avail_emulator_if;

    logic fifo_wr_beat;
    logic fifo_rd_beat;
    logic fifo_clear;

    modport master (
        output fifo_wr_beat,
        output fifo_rd_beat,
        output fifo_clear
    );

    modport slave (
        input fifo_wr_beat,
        input fifo_rd_beat,
        input fifo_clear
    );

endinterface

// File: rtl/dma_block_avail_emulator_fifo_level_tracker.sv
// Dword occupancy counter for the tb AXI FIFO.
// Holds at empty/full and latches sticky error flags.
module dma_fifo_level_tracker
    import caliptra_top_tb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     cptra_rst_b,
    dma_block_avail_emulator_if.slave beat,
    output logic [CNT_W-1:0]         level,
    output logic [CNT_W-1:0]         next_level,
    output logic                     err_underflow,
    output logic                     err_overflow
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic push_only;
    logic pop_only;
    logic uf_hit;
    logic of_hit;

    always_comb begin
        push_only = beat.fifo_wr_beat & ~beat.fifo_rd_beat;
        pop_only  = beat.fifo_rd_beat & ~beat.fifo_wr_beat;
        uf_hit    = ~beat.fifo_clear & pop_only
                  & (level == '0);
        of_hit    = ~beat.fifo_clear & push_only
                  & (level == FULL);
        next_level = level;
        // a flush wins over any beat in the same cycle
        if (beat.fifo_clear) begin
            next_level = '0;
        end else if (pop_only && level != '0) begin
            next_level = level - 1'b1;
        end else if (push_only && level != FULL) begin
            next_level = level + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!cptra_rst_b) begin
            level         <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            level         <= next_level;
            err_underflow <= err_underflow | uf_hit;
            err_overflow  <= err_overflow | of_hit;
        end
    end

endmodule

// File: rtl/dma_block_avail_emulator.sv
// Emulates recovery_data_avail: announces data once a full block
// of the active testcase is buffered in the tb AXI FIFO.
module dma_block_avail_emulator
    import caliptra_top_tb_pkg::*;
#(
    parameter int NUM_TC        = 100,
    parameter int BLOCK_W       = 12,
    parameter int FIFO_DEPTH_DW = 1024,
    parameter int CNT_W         = $clog2(FIFO_DEPTH_DW + 1)
) (
    input  logic                             clk,
    input  logic                             cptra_rst_b,
    input  logic                             dma_gen_done,
    input  logic [NUM_TC-1:0][BLOCK_W-1:0]   dma_gen_block_size,
    input  logic                             tc_advance,
    dma_block_avail_emulator_if.slave        beat,
    output logic                             recovery_data_avail,
    output logic [6:0]                       cur_tc_idx,
    output logic [CNT_W-1:0]                 fifo_level,
    output logic [15:0]                      blocks_released,
    output logic                             err_underflow,
    output logic                             err_overflow
);

    localparam int TW = (CNT_W > BLOCK_W - 1) ? CNT_W : BLOCK_W - 1;
    localparam int IW = (NUM_TC > 1) ? $clog2(NUM_TC) : 1;
    localparam logic [6:0] LAST_TC = 7'(NUM_TC - 1);

    dma_avail_state_e state, state_d;

    logic [TW-1:0]      thr_q, thr_d;
    logic [TW-1:0]      drained_q, drained_d;
    logic [TW-1:0]      drained_inc;
    logic [TW-1:0]      thr_load;
    logic [TW-1:0]      lvl_ext;
    logic [6:0]         idx_d;
    logic [15:0]        blk_d;
    logic [BLOCK_W-1:0] bs_sel;
    logic [CNT_W-1:0]   next_level;
    logic               rd;
    logic               clr;

    dma_fifo_level_tracker #(
        .DEPTH (FIFO_DEPTH_DW),
        .CNT_W (CNT_W)
    ) u_level (
        .clk           (clk),
        .cptra_rst_b   (cptra_rst_b),
        .beat          (beat),
        .level         (fifo_level),
        .next_level    (next_level),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    always_comb begin
        rd          = beat.fifo_rd_beat;
        clr         = beat.fifo_clear;
        bs_sel      = dma_gen_block_size[cur_tc_idx[IW-1:0]];
        thr_load    = TW'(ceil_div4(32'(bs_sel)));
        lvl_ext     = TW'(next_level);
        drained_inc = drained_q + TW'(rd);
    end

    always_comb begin
        state_d   = state;
        thr_d     = thr_q;
        drained_d = drained_q;
        idx_d     = cur_tc_idx;
        blk_d     = blocks_released;
        if (clr) begin
            drained_d = '0;
        end
        unique case (state)
            DMA_AV_IDLE: begin
                if (dma_gen_done) begin
                    state_d = DMA_AV_LOAD;
                end
            end
            DMA_AV_DONE: begin
            end
            default: begin
                // advance outranks every in-testcase transition
                if (tc_advance) begin
                    drained_d = '0;
                    blk_d     = '0;
                    if (cur_tc_idx == LAST_TC) begin
                        state_d = DMA_AV_DONE;
                    end else begin
                        idx_d   = cur_tc_idx + 7'd1;
                        state_d = DMA_AV_LOAD;
                    end
                end else begin
                    unique case (state)
                        DMA_AV_LOAD: begin
                            thr_d   = thr_load;
                            state_d = (thr_load == '0)
                                    ? DMA_AV_BYPASS
                                    : DMA_AV_FILL;
                        end
                        DMA_AV_FILL: begin
                            if (!clr && lvl_ext >= thr_q) begin
                                state_d = DMA_AV_AVAIL;
                            end
                        end
                        DMA_AV_AVAIL: begin
                            if (clr) begin
                                state_d = DMA_AV_FILL;
                            end else if (rd) begin
                                if (drained_inc == thr_q) begin
                                    state_d   = DMA_AV_FILL;
                                    drained_d = '0;
                                    blk_d     = (blocks_released == 16'hFFFF)
                                              ? blocks_released
                                              : blocks_released + 16'd1;
                                end else begin
                                    drained_d = drained_inc;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!cptra_rst_b) begin
            state               <= DMA_AV_IDLE;
            thr_q               <= '0;
            drained_q           <= '0;
            cur_tc_idx          <= '0;
            blocks_released     <= '0;
            recovery_data_avail <= 1'b0;
        end else begin
            state               <= state_d;
            thr_q               <= thr_d;
            drained_q           <= drained_d;
            cur_tc_idx          <= idx_d;
            blocks_released     <= blk_d;
            recovery_data_avail <= (state_d == DMA_AV_AVAIL);
        end
    end

endmodule

// File: tb/tb_dma_block_avail_emulator.sv
// Randomized + directed scoreboard bench for dma_block_avail_emulator.
// A spec-level model predicts outputs; a negedge monitor compares.
module tb_dma_block_avail_emulator;

    localparam int NTC   = 3;
    localparam int BW    = 12;
    localparam int DEPTH = 1024;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam int PH_IDLE   = 0;
    localparam int PH_LOAD   = 1;
    localparam int PH_BYPASS = 2;
    localparam int PH_FILL   = 3;
    localparam int PH_AVAIL  = 4;
    localparam int PH_DONE   = 5;

    logic                     clk = 1'b0;
    logic                     rst_b;
    logic                     done;
    logic                     adv;
    logic [NTC-1:0][BW-1:0]   bs;
    logic                     avail_o;
    logic [6:0]               idx_o;
    logic [CW-1:0]            lvl_o;
    logic [15:0]              blk_o;
    logic                     uf_o;
    logic                     of_o;

    dma_block_avail_emulator_if bif ();

    dma_block_avail_emulator #(
        .NUM_TC        (NTC),
        .BLOCK_W       (BW),
        .FIFO_DEPTH_DW (DEPTH)
    ) dut (
        .clk                 (clk),
        .cptra_rst_b         (rst_b),
        .dma_gen_done        (done),
        .dma_gen_block_size  (bs),
        .tc_advance          (adv),
        .beat                (bif.slave),
        .recovery_data_avail (avail_o),
        .cur_tc_idx          (idx_o),
        .fifo_level          (lvl_o),
        .blocks_released     (blk_o),
        .err_underflow       (uf_o),
        .err_overflow        (of_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit avail;
        int idx;
        int level;
        int blocks;
        bit uf;
        bit of;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int m_ph, m_idx, m_level, m_thr, m_drained, m_blocks;
    bit m_uf, m_of;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, expv);
        end
    endtask

    // reference behaviour, one clock edge at a time
    task automatic model(input bit r, input bit d, input bit w,
                         input bit rd, input bit c, input bit a);
        int nl;
        if (!r) begin
            m_ph = PH_IDLE; m_idx = 0; m_level = 0; m_thr = 0;
            m_drained = 0; m_blocks = 0; m_uf = 0; m_of = 0;
            return;
        end
        nl = m_level;
        if (c) nl = 0;
        else if (w && rd) nl = m_level;
        else if (rd) begin
            if (m_level == 0) m_uf = 1;
            else nl = m_level - 1;
        end else if (w) begin
            if (m_level == DEPTH) m_of = 1;
            else nl = m_level + 1;
        end
        if (c) m_drained = 0;
        if (m_ph == PH_IDLE) begin
            if (d) m_ph = PH_LOAD;
        end else if (m_ph != PH_DONE) begin
            if (a) begin
                m_drained = 0;
                m_blocks = 0;
                if (m_idx == NTC - 1) m_ph = PH_DONE;
                else begin
                    m_idx++;
                    m_ph = PH_LOAD;
                end
            end else if (m_ph == PH_LOAD) begin
                m_thr = (int'(bs[m_idx]) + 3) / 4;
                m_ph = (m_thr == 0) ? PH_BYPASS : PH_FILL;
            end else if (m_ph == PH_AVAIL && c) begin
                m_ph = PH_FILL;
            end else if (m_ph == PH_FILL) begin
                if (nl >= m_thr) m_ph = PH_AVAIL;
            end else if (m_ph == PH_AVAIL && rd) begin
                if (m_drained + 1 == m_thr) begin
                    m_ph = PH_FILL;
                    m_drained = 0;
                    if (m_blocks < 65535) m_blocks++;
                end else begin
                    m_drained++;
                end
            end
        end
        m_level = nl;
    endtask

    task automatic step(input bit r, input bit d, input bit w,
                        input bit rd, input bit c, input bit a);
        exp_t e;
        rst_b = r;
        done = d;
        bif.fifo_wr_beat = w;
        bif.fifo_rd_beat = rd;
        bif.fifo_clear = c;
        adv = a;
        model(r, d, w, rd, c, a);
        e.avail = (m_ph == PH_AVAIL);
        e.idx = m_idx;
        e.level = m_level;
        e.blocks = m_blocks;
        e.uf = m_uf;
        e.of = m_of;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 1, 0, 0, 0);
    endtask

    task automatic pop(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 1, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
    endtask

    task automatic restart();
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
    endtask

    task automatic rand_episode(input int n);
        bit w, rd, c, a;
        for (int i = 0; i < NTC; i++) begin
            bs[i] = ($urandom_range(0, 3) == 0)
                  ? 12'd0 : 12'($urandom_range(1, 60));
        end
        restart();
        for (int i = 0; i < n; i++) begin
            w  = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 45);
            c  = ($urandom_range(0, 99) < 2);
            a  = ($urandom_range(0, 99) < 2);
            step(1, 1, w, rd, c, a);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("avail", int'(avail_o), int'(e.avail));
            chk("tc_idx", int'(idx_o), e.idx);
            chk("level", int'(lvl_o), e.level);
            chk("blocks", int'(blk_o), e.blocks);
            chk("err_uf", int'(uf_o), int'(e.uf));
            chk("err_of", int'(of_o), int'(e.of));
        end
    end

    initial begin
        bs = '0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // 64-byte block: 16 dwords gate avail
        bs[0] = 12'd64;
        restart();
        push(15);
        idle(2);
        push(1);
        idle(2);
        pop(16);
        idle(3);

        // 6-byte block: two 2-dword releases
        bs[0] = 12'd6;
        restart();
        push(4);
        for (int i = 0; i < 4; i++) begin
            pop(1);
            idle(1);
        end
        idle(2);

        // bypass: pushes never raise avail
        bs[0] = 12'd0;
        restart();
        push(100);
        idle(2);

        // simultaneous beats, underflow
        restart();
        push(5);
        step(1, 1, 1, 1, 0, 0);
        pop(6);
        idle(1);

        // clear while a block is available
        bs[0] = 12'd8;
        restart();
        push(3);
        step(1, 1, 0, 0, 1, 0);
        idle(2);

        // overflow at full depth
        bs[0] = 12'd0;
        restart();
        push(DEPTH + 1);
        idle(1);

        // testcase stepping to DONE
        bs[0] = 12'd16;
        bs[1] = 12'd0;
        bs[2] = 12'd32;
        restart();
        push(5);
        step(1, 1, 0, 0, 0, 1);
        idle(2);
        step(1, 1, 0, 0, 0, 1);
        idle(3);
        push(4);
        step(1, 1, 0, 0, 0, 1);
        push(10);
        step(1, 1, 0, 0, 0, 1);
        pop(3);

        // reset while avail with level 12
        bs[0] = 12'd32;
        restart();
        push(12);
        idle(1);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        idle(1);
        push(8);
        idle(2);

        for (int k = 0; k < 5; k++) rand_episode(500);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
